// File: rtl/i2s_tx.sv
`default_nettype none
// ============================================================================
//  Module   : i2s_tx
//  Purpose  : Stereo I2S transmitter. Accepts signed left/right sample pairs
//             and serializes them MSB-first onto an I2S link toward a DAC.
//             BCLK and LRCLK are derived from the system clock. A one-cycle
//             frame-start strobe paces the upstream sample producer.
//
//  Ports    : i_clk       system clock; all logic runs on its rising edge
//             i_rst_n     asynchronous active-low reset
//             i_en        run enable; low holds the block in its start state
//             i_valid     strobe: i_left/i_right carry a new sample pair
//             i_left      left sample (two's complement)
//             i_right     right sample (two's complement)
//             o_samp_req  one-cycle pulse at each frame start
//             o_bclk      I2S bit clock
//             o_lrclk     word select (0 = left slot, 1 = right slot)
//             o_sdata     serial data, MSB first, zero padded to slot width
//             o_underrun  pulse: frame started with no new pair available
//             o_overrun   pulse: new pair arrived over an unconsumed one
//
//  Revision : 1.0  initial release
// ============================================================================
module i2s_tx #(
    parameter int SAMP_WIDTH = 24,
    parameter int SLOT_WIDTH = 32,
    parameter int BCLK_DIV   = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic                  i_valid,
    input  logic [SAMP_WIDTH-1:0] i_left,
    input  logic [SAMP_WIDTH-1:0] i_right,
    output logic                  o_samp_req,
    output logic                  o_bclk,
    output logic                  o_lrclk,
    output logic                  o_sdata,
    output logic                  o_underrun,
    output logic                  o_overrun
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_div_w = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int c_bit_w = $clog2(2 * SLOT_WIDTH);

    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(BCLK_DIV - 1);
    localparam logic [c_div_w-1:0] c_div_half = c_div_w'(BCLK_DIV / 2 - 1);
    localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(2 * SLOT_WIDTH - 1);
    localparam logic [c_bit_w-1:0] c_slot     = c_bit_w'(SLOT_WIDTH);
    localparam logic [c_bit_w-1:0] c_lr_rise  = c_bit_w'(SLOT_WIDTH - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [c_div_w-1:0]    r_div_cnt;
    logic [c_bit_w-1:0]    r_bit_cnt;
    logic [SAMP_WIDTH-1:0] r_pend_l;
    logic [SAMP_WIDTH-1:0] r_pend_r;
    logic                  r_fresh;
    logic [SAMP_WIDTH-1:0] r_sh_l;
    logic [SAMP_WIDTH-1:0] r_sh_r;
    logic                  r_bclk;
    logic                  r_lrclk;
    logic                  r_sdata;
    logic                  r_samp_req;
    logic                  r_underrun;
    logic                  r_overrun;

    // ------------------------------------------------------------------------
    // Timing decode
    // ------------------------------------------------------------------------
    logic                  w_tick;
    logic                  w_bclk_rise;
    logic                  w_frame_start;
    logic [c_bit_w-1:0]    w_bit_nxt;

    // A tick is the last system cycle of a BCLK period; everything that
    // moves on the serial link changes on it, coincident with BCLK falling.
    assign w_tick        = (r_div_cnt == c_div_last);
    assign w_bclk_rise   = (r_div_cnt == c_div_half);
    assign w_bit_nxt     = (r_bit_cnt == c_bit_last) ? '0 : r_bit_cnt + 1'b1;
    assign w_frame_start = w_tick && (r_bit_cnt == c_bit_last);

    // ------------------------------------------------------------------------
    // Divider, bit counter and BCLK
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div_cnt <= '0;
            r_bit_cnt <= c_bit_last;
            r_bclk    <= 1'b0;
        end else if (!i_en) begin
            r_div_cnt <= '0;
            r_bit_cnt <= c_bit_last;
            r_bclk    <= 1'b0;
        end else begin
            if (w_tick) begin
                r_div_cnt <= '0;
                r_bit_cnt <= w_bit_nxt;
                r_bclk    <= 1'b0;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
                if (w_bclk_rise) begin
                    r_bclk <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Pending pair buffer and status strobes
    // ------------------------------------------------------------------------
    // Only the frame-start tick consumes the pending pair. A strobe landing on
    // that same edge is therefore not an overrun: the old pair is taken into
    // the shift registers while the new one refills pending for next frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pend_l   <= '0;
            r_pend_r   <= '0;
            r_fresh    <= 1'b0;
            r_samp_req <= 1'b0;
            r_underrun <= 1'b0;
            r_overrun  <= 1'b0;
        end else if (!i_en) begin
            // Pending data survives a disable so it can be replayed later.
            r_fresh    <= 1'b0;
            r_samp_req <= 1'b0;
            r_underrun <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_samp_req <= w_frame_start;
            r_underrun <= w_frame_start && !r_fresh;
            r_overrun  <= i_valid && r_fresh && !w_frame_start;

            if (i_valid) begin
                r_pend_l <= i_left;
                r_pend_r <= i_right;
            end

            if (w_frame_start) begin
                r_fresh <= i_valid;
            end else if (i_valid) begin
                r_fresh <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Serializer and word select
    // ------------------------------------------------------------------------
    // Each slot shifts its own register left, zero filling, so bits past the
    // sample width come out as the required zero padding with no extra test.
    // The left MSB is driven straight from pending on the frame-start tick,
    // hence the left register is loaded already advanced by one bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sh_l  <= '0;
            r_sh_r  <= '0;
            r_sdata <= 1'b0;
            r_lrclk <= 1'b0;
        end else if (!i_en) begin
            r_sh_l  <= '0;
            r_sh_r  <= '0;
            r_sdata <= 1'b0;
            r_lrclk <= 1'b0;
        end else if (w_tick) begin
            if (w_frame_start) begin
                r_sh_l  <= r_pend_l << 1;
                r_sh_r  <= r_pend_r;
                r_sdata <= r_pend_l[SAMP_WIDTH-1];
            end else if (w_bit_nxt < c_slot) begin
                r_sh_l  <= r_sh_l << 1;
                r_sdata <= r_sh_l[SAMP_WIDTH-1];
            end else begin
                r_sh_r  <= r_sh_r << 1;
                r_sdata <= r_sh_r[SAMP_WIDTH-1];
            end

            // LRCLK leads the slot data by one BCLK.
            if (w_bit_nxt == c_lr_rise) begin
                r_lrclk <= 1'b1;
            end else if (w_bit_nxt == c_bit_last) begin
                r_lrclk <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs (all registered)
    // ------------------------------------------------------------------------
    assign o_samp_req = r_samp_req;
    assign o_bclk     = r_bclk;
    assign o_lrclk    = r_lrclk;
    assign o_sdata    = r_sdata;
    assign o_underrun = r_underrun;
    assign o_overrun  = r_overrun;

endmodule
`default_nettype wire

// File: doc/i2s_tx.md
# i2s_tx

Stereo I2S transmitter at the output end of the audio DSP chain. It takes filtered, gain-scaled samples (e.g. `o_fir_data` from the FIR top) and serializes them MSB-first onto an I2S link toward a DAC. It generates BCLK/LRCLK from the system clock. It also emits the one-cycle sample-rate strobe that paces the upstream FIR (drives its `i_clk_fir`), so the whole chain runs at the DAC frame rate.

## Interface
- `SAMP_WIDTH`, 24, sample word width (two's complement); must be ≤ `SLOT_WIDTH`.
- `SLOT_WIDTH`, 32, BCLK periods per channel slot.
- `BCLK_DIV`, 4, `i_clk` cycles per BCLK period; even, ≥ 2.

- `i_clk`, in, 1, system clock. This block uses one clock; all logic is on its rising edge.
- `i_rst_n`, in, 1, asynchronous active-low reset.
- `i_en`, in, 1, run enable. Low holds the block in its start state.
- `i_valid`, in, 1, one-cycle strobe: `i_left`/`i_right` hold a new sample pair.
- `i_left`, in, `SAMP_WIDTH`, left sample (signed).
- `i_right`, in, `SAMP_WIDTH`, right sample (signed).
- `o_samp_req`, out, 1, one-cycle pulse at each frame start (sample-rate strobe).
- `o_bclk`, out, 1, I2S bit clock.
- `o_lrclk`, out, 1, word select: 0 = left slot, 1 = right slot.
- `o_sdata`, out, 1, serial data.
- `o_underrun`, out, 1, one-cycle pulse: a frame started with no new pair since the previous frame start.
- `o_overrun`, out, 1, one-cycle pulse: `i_valid` arrived while an unconsumed pair was pending.

## Operation
- **Counters**
  - `div_cnt` counts 0..`BCLK_DIV`−1.
  - `bit_cnt` counts 0..2·`SLOT_WIDTH`−1 and advances on each tick.
  - A tick is an edge where `div_cnt` = `BCLK_DIV`−1.
  - Frame rate = f_clk / (`BCLK_DIV`·2·`SLOT_WIDTH`). Defaults give 256 cycles per frame.
- **Pending buffer**
  - `i_valid` captures `i_left`/`i_right` into pending registers and sets `fresh`.
  - If `fresh` is already set and no tick consumes it on that edge, pulse `o_overrun`. The latest pair wins.
- **Frame start** (tick where `bit_cnt` wraps to 0):
  - Pending is copied into the left and right shift registers.
  - `o_samp_req` pulses.
  - If `fresh` = 0, `o_underrun` pulses and the previous pair is retransmitted.
  - `fresh` clears, unless `i_valid` is high on the same edge. In that case the new pair goes to pending, `fresh` stays 1, and the pair is used in the next frame. No overrun is flagged.
- **Serial data**
  - At bit k of the left slot (k = 0..`SLOT_WIDTH`−1), `o_sdata` = left[`SAMP_WIDTH`−1−k] for k < `SAMP_WIDTH`, otherwise 0.
  - The right slot does the same at k = `bit_cnt`−`SLOT_WIDTH`.
- **LRCLK** (standard I2S one-bit lead)
  - `o_lrclk` goes to 1 at the tick entering `bit_cnt` = `SLOT_WIDTH`−1.
  - It goes to 0 at the tick entering `bit_cnt` = 2·`SLOT_WIDTH`−1.
  - The MSB therefore follows the LRCLK edge by exactly one BCLK.
- **`i_en` low**
  - On the next edge, counters return to the start state and outputs return to reset values.
  - `fresh` clears; pending data is retained.
  - When `i_en` rises, operation restarts from the start state.

## Timing
- **Reset values:** `o_bclk` = 0, `o_lrclk` = 0, `o_sdata` = 0, `o_samp_req` = 0, `o_underrun` = 0, `o_overrun` = 0.
- **Start state:** `div_cnt` = 0, `bit_cnt` = 2·`SLOT_WIDTH`−1, `fresh` = 0, pending and shift registers = 0.
- **Outputs:** all registered, no combinational paths from inputs.
- **BCLK edges**
  - `o_bclk` rises on the edge where `div_cnt` = `BCLK_DIV`/2−1.
  - `o_bclk` falls on the tick edge.
  - `o_sdata` and `o_lrclk` change only on tick edges, i.e. coincident with the BCLK falling edge. They are stable across the rising edge.
- **First frame:** the first tick after reset or enable occurs `BCLK_DIV` cycles later. That tick is a frame start with an `o_underrun` pulse, since no pair is pending yet.
- **Sample latency:** a pair accepted in frame N is transmitted in frame N+1. Its MSB appears on the frame-start tick.
- **Reset mid-frame:** asynchronous return to the reset and start state. Partial output is abandoned.

## Test plan
- **Bit order:** defaults, `i_valid` with left = 0x800001 and right = 0x7FFFFE before the 2nd frame. In frame 2:
  - left slot serializes 1, 22×0, 1, then 8×0 with `o_lrclk` = 0;
  - right slot serializes 0, 22×1, 0, then 8×0 with `o_lrclk` = 1;
  - the LRCLK falling edge precedes the left MSB by one BCLK (4 cycles).
- **Clocking:** after reset, `o_bclk` period = 4 cycles at 50% duty; `o_samp_req` pulses every 256 cycles; the first tick arrives at cycle 4 and carries `o_underrun` = 1.
- **Underrun:** supply a pair only every other frame. `o_underrun` pulses on alternate frame starts, and the prior pair is repeated bit-exact.
- **Overrun and simultaneous events:**
  - two `i_valid` strobes (0x111111, then 0x222222) within one frame → one `o_overrun` pulse, and 0x222222 is sent;
  - `i_valid` on the same edge as `o_samp_req` → no overrun, and that pair is sent in the following frame.
- **Loopback:** drive `i_valid` from `o_samp_req` delayed 10 cycles with an incrementing pair. There is never an underrun or overrun after the first frame, and each frame carries the value requested one frame earlier.
- **Reset and enable:** assert `i_rst_n` low mid-right-slot → all outputs are 0 immediately. Drop `i_en` mid-frame, then raise it → output restarts from the start state with an `o_underrun` pulse at the first tick.
